dmux_4way: RTL and testbench
============================

// Module: dmux_4way
// PURPOSE
//   1-to-4 demultiplexer: routes data input `in` to exactly one of four outputs, chosen by the 2-bit `sel`.
//   All non-selected outputs are driven to 0.
//   Used as a basic routing primitive, for example in write-enable fan-out for RAM banks and register selection.
//   The outputs are registered by default. A combinational build option gives gate-equivalent timing.
// PARAMETERS
//   WIDTH    1   data width of `in` and of each output y0..y3
//   REG_OUT  1   1 = outputs registered (1-cycle latency); 0 = purely combinational, clk/rst unused
// PORTS
//   clk  input   1      single clock; rising edge active
//   rst  input   1      synchronous, active-high reset
//   in   input   WIDTH  data to route
//   sel  input   2      output select: 00->y0, 01->y1, 10->y2, 11->y3
//   y3   output  WIDTH  receives `in` when sel==2'b11, else 0
//   y2   output  WIDTH  receives `in` when sel==2'b10, else 0
//   y1   output  WIDTH  receives `in` when sel==2'b01, else 0
//   y0   output  WIDTH  receives `in` when sel==2'b00, else 0
//   Positional port order is fixed as listed: clk, rst, in, sel, y3, y2, y1, y0.
// BEHAVIOUR
//   - One clock domain. Reset is synchronous and active-high.
//   - REG_OUT=1, on each rising clk edge:
//       rst==1 : y0=y1=y2=y3=0. This takes priority over everything else.
//       rst==0 : y[sel] <= in; the other three outputs <= 0.
//   - REG_OUT=1 latency: exactly 1 cycle from in/sel to outputs. No handshake; every cycle is valid.
//   - REG_OUT=1 power-up: output values are undefined until the first reset edge. A bench must reset before checking.
//   - REG_OUT=1, reset mid-operation: outputs read 0 in the cycle after the reset edge.
//       Normal routing resumes on the first edge with rst==0.
//   - REG_OUT=0: outputs follow `in`/`sel` combinationally with zero latency. rst has no effect.
//   - Bit-wise rule, i = 0..3: yi = in & {WIDTH{sel==i}}.
//       At most one output is non-zero at any time.
//       With in==0, all outputs are 0 for every sel.
//   - Sequencing sel through 00->01->10->11->00 moves `in` across y0..y3 with no overlap cycle.
//   - sel wrap-around from 11 to 00 needs no special handling.
//   - sel containing X/Z: all outputs go to 0 (registered, or combinational when REG_OUT=0).
//       Use a full decode with default = 0. Never latch or hold a previous value.
// STRUCTURE
//   - Shared package dmux_pkg:
//       localparams SEL_Y0=2'b00, SEL_Y1=2'b01, SEL_Y2=2'b10, SEL_Y3=2'b11.
//       typedef sel2_t = logic [1:0].
//   - Sub-module dmux_2way (in, sel, a, b), combinational, 2 outputs, WIDTH-parameterised.
//   - Decode tree in dmux_4way:
//       first stage: one dmux_2way on sel[1], splits in into lo/hi;
//       second stage: two dmux_2way on sel[0] give y0/y1 and y2/y3.
//   - An optional output register stage wraps the tree (generate on REG_OUT).
// TESTING
//   Use REG_OUT=1, WIDTH=1 unless stated. Sample one cycle after applying stimulus.
//   1. rst=1 for 2 edges, with in=1 and sel=10 -> y3..y0 = 0000.
//   2. rst=0, in=0, sel stepped 00,01,10,11 -> y3..y0 = 0000 every cycle.
//   3. in=1, sel stepped 00,01,10,11 -> y3..y0 = 0001, 0010, 0100, 1000.
//   4. in=1, sel=11 then 00 (wrap) -> y3..y0 = 1000 then 0001; y3 clears in the same cycle y0 sets.
//   5. in=1, sel=01 steady, then rst=1 for one edge -> 0000; rst=0 on the next edge -> 0010.
//   6. WIDTH=8, REG_OUT=0, in=8'hA5, sel=10 -> y2=8'hA5 and y0=y1=y3=8'h00 with zero delay.
//      Also sel=2'bx1 -> all outputs 0.

Source files
------------

// File: rtl/dmux_pkg.sv
// Shared definitions for the demultiplexer family: select encodings and the
// select-code type used by dmux_4way.
package dmux_pkg;

    typedef logic [1:0] sel2_t;

    localparam sel2_t SEL_Y0 = 2'b00;
    localparam sel2_t SEL_Y1 = 2'b01;
    localparam sel2_t SEL_Y2 = 2'b10;
    localparam sel2_t SEL_Y3 = 2'b11;

endpackage : dmux_pkg

// File: rtl/dmux_2way.sv
// Combinational 1-to-2 demultiplexer: `in` goes to `a` when sel==0, to `b`
// when sel==1; the other output is 0, and an unknown select clears both.
module dmux_2way #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] in,
    input  logic             sel,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b
);

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can
        // leave a value unassigned and infer a latch.
        a = '0;
        b = '0;
        case (sel)
            1'b0:    a = in;
            1'b1:    b = in;
            default: ;
        endcase
    end

endmodule : dmux_2way

// File: rtl/dmux_4way.sv
// 1-to-4 demultiplexer built as a two-level tree of dmux_2way, with an
// optional output register (REG_OUT=1) using a synchronous active-high reset.
module dmux_4way
    import dmux_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  sel2_t            sel,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y0
);

    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;

    // sel[1] picks the half, sel[0] picks the output within it.
    dmux_2way #(.WIDTH(WIDTH)) u_stage_hi_lo (
        .in  (in),
        .sel (sel[1]),
        .a   (lo),
        .b   (hi)
    );

    dmux_2way #(.WIDTH(WIDTH)) u_stage_lo (
        .in  (lo),
        .sel (sel[0]),
        .a   (d0),
        .b   (d1)
    );

    dmux_2way #(.WIDTH(WIDTH)) u_stage_hi (
        .in  (hi),
        .sel (sel[0]),
        .a   (d2),
        .b   (d3)
    );

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] q0;
        logic [WIDTH-1:0] q1;
        logic [WIDTH-1:0] q2;
        logic [WIDTH-1:0] q3;

        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        always_ff @(posedge clk) begin
            if (rst) begin
                q0 <= '0;
                q1 <= '0;
                q2 <= '0;
                q3 <= '0;
            end else begin
                q0 <= d0;
                q1 <= d1;
                q2 <= d2;
                q3 <= d3;
            end
        end

        assign y0 = q0;
        assign y1 = q1;
        assign y2 = q2;
        assign y3 = q3;
    end else begin : g_comb
        // Clock and reset have no function in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

        assign y0 = d0;
        assign y1 = d1;
        assign y2 = d2;
        assign y3 = d3;
    end

endmodule : dmux_4way

// File: tb/tb_dmux_4way.sv
// Self-checking bench for dmux_4way: registered WIDTH=1 instance checked via a
// scoreboard queue, plus a combinational WIDTH=8 instance checked inline.
module tb_dmux_4way;

    logic       clk;
    logic       rst;
    logic       in;
    logic [1:0] sel;
    logic       y3, y2, y1, y0;

    logic [7:0] c_in;
    logic [1:0] c_sel;
    logic       c_rst;
    logic [7:0] c_y3, c_y2, c_y1, c_y0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] exp;
        string      name;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    dmux_4way #(.WIDTH(1), .REG_OUT(1'b1)) u_dut_reg (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .sel (sel),
        .y3  (y3),
        .y2  (y2),
        .y1  (y1),
        .y0  (y0)
    );

    dmux_4way #(.WIDTH(8), .REG_OUT(1'b0)) u_dut_comb (
        .clk (clk),
        .rst (c_rst),
        .in  (c_in),
        .sel (c_sel),
        .y3  (c_y3),
        .y2  (c_y2),
        .y1  (c_y1),
        .y0  (c_y0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Reference: one-hot placement of `in`, cleared on reset.
    function automatic logic [3:0] model1(input logic r, input logic i, input logic [1:0] s);
        logic [3:0] v;
        v = 4'b0000;
        if (!r) v[s] = i;
        return v;
    endfunction

    function automatic logic [31:0] model8(input logic [7:0] d, input logic [1:0] s);
        logic [31:0] v;
        v = '0;
        if (!$isunknown(s)) v[s*8 +: 8] = d;
        return v;
    endfunction

    // Drive one cycle of stimulus, push its expectation, then compare after the edge.
    task automatic cycle(input logic r, input logic i, input logic [1:0] s, input string name);
        sb_entry_t e;
        logic [3:0] got;
        rst = r;
        in  = i;
        sel = s;
        sb_q.push_back('{exp: model1(r, i, s), name: name});
        @(posedge clk);
        #1;
        got = {y3, y2, y1, y0};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %b", name, got);
        end else begin
            e = sb_q.pop_front();
            if (got !== e.exp) begin
                errors++;
                $display("FAIL %s: y3..y0 got %b expected %b", e.name, got, e.exp);
            end
        end
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 2'b10, "reset_edge1");
        cycle(1'b1, 1'b1, 2'b10, "reset_edge2");
    endtask

    task automatic test_zero_data();
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 2'(k), "zero_data");
    endtask

    task automatic test_routing();
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 2'(k), "route_one");
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b1, 2'b11, "wrap_sel11");
        cycle(1'b0, 1'b1, 2'b00, "wrap_sel00");
    endtask

    task automatic test_mid_reset();
        cycle(1'b0, 1'b1, 2'b01, "steady_sel01_a");
        cycle(1'b0, 1'b1, 2'b01, "steady_sel01_b");
        cycle(1'b1, 1'b1, 2'b01, "mid_reset");
        cycle(1'b0, 1'b1, 2'b01, "resume_after_reset");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 40; k++)
            cycle(($urandom_range(0, 9) == 0), 1'($urandom), 2'($urandom), "random_b2b");
    endtask

    task automatic comb_check(input logic [7:0] d, input logic [1:0] s, input string name);
        logic [31:0] exp;
        logic [31:0] got;
        c_in  = d;
        c_sel = s;
        c_rst = ~c_rst;
        #1;
        exp = model8(d, c_sel);
        got = {c_y3, c_y2, c_y1, c_y0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: y3..y0 got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_comb();
        logic [1:0] xsel;
        comb_check(8'hA5, 2'b10, "comb_a5_sel10");
        comb_check(8'hA5, 2'b00, "comb_a5_sel00");
        comb_check(8'h3C, 2'b01, "comb_3c_sel01");
        comb_check(8'hFF, 2'b11, "comb_ff_sel11");
        comb_check(8'h00, 2'b10, "comb_zero_data");
        xsel = 2'bx1;
        comb_check(8'hA5, xsel, "comb_sel_x1");
    endtask

    initial begin
        rst   = 1'b1;
        in    = 1'b0;
        sel   = 2'b00;
        c_rst = 1'b0;
        c_in  = 8'h00;
        c_sel = 2'b00;

        test_reset();
        test_zero_data();
        test_routing();
        test_wrap();
        test_mid_reset();
        test_back_to_back();
        test_comb();

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dmux_4way
